// File: rtl/fb_port_a_ctrl.sv
// Frame buffer port A arbiter: CPU pixel bus with priority over a rectangle-fill engine.
// Optional FB_CLEAR_ON_RESET_EN: clear the whole screen to 0 on reset release.
module fb_port_a_ctrl #(
    parameter int HOR_RES  = 320,
    parameter int VERT_RES = 240,
    parameter int X_W      = 9,
    parameter int Y_W      = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CPU_REQ,
    input  logic               CPU_WE,
    input  logic [X_W-1:0]     CPU_X,
    input  logic [Y_W-1:0]     CPU_Y,
    input  logic               CPU_WDATA,
    output logic               CPU_RD_VALID,
    output logic               CPU_RD_DATA,
    input  logic               FILL_START,
    input  logic [X_W-1:0]     FILL_X0,
    input  logic [X_W-1:0]     FILL_X1,
    input  logic [Y_W-1:0]     FILL_Y0,
    input  logic [Y_W-1:0]     FILL_Y1,
    input  logic               FILL_COLOUR,
    output logic               FILL_BUSY,
    output logic               FILL_DONE,
    output logic [Y_W+X_W-1:0] FB_ADDR,
    output logic               FB_WE,
    output logic               FB_DATA_IN,
    input  logic               FB_DATA_OUT
);

    localparam logic [X_W-1:0] H_RES  = X_W'(HOR_RES);
    localparam logic [Y_W-1:0] V_RES  = Y_W'(VERT_RES);
    localparam logic [X_W-1:0] X_LAST = X_W'(HOR_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(VERT_RES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [X_W-1:0] x0, x1, cx;
    logic [Y_W-1:0] y0, y1, cy;
    logic           colour;
    logic           rd_p1, rd_p2;
    logic           ok1, ok2;

    logic           cpu_inr;
    logic [X_W-1:0] fx1;
    logic [Y_W-1:0] fy1;
    logic           fill_ok;
    logic           fill_go;

    assign cpu_inr = (CPU_X < H_RES) && (CPU_Y < V_RES);
    assign fx1     = (FILL_X1 > X_LAST) ? X_LAST : FILL_X1;
    assign fy1     = (FILL_Y1 > Y_LAST) ? Y_LAST : FILL_Y1;
    assign fill_ok = (FILL_X0 <= fx1) && (FILL_Y0 <= fy1)
                  && (FILL_X0 < H_RES) && (FILL_Y0 < V_RES);
    assign fill_go = (state == RUN) && !CPU_REQ;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            FB_ADDR      <= '0;
            FB_WE        <= 1'b0;
            FB_DATA_IN   <= 1'b0;
            CPU_RD_VALID <= 1'b0;
            CPU_RD_DATA  <= 1'b0;
            FILL_DONE    <= 1'b0;
            rd_p1        <= 1'b0;
            rd_p2        <= 1'b0;
            ok1          <= 1'b0;
            ok2          <= 1'b0;
            x0           <= '0;
            y0           <= '0;
            cx           <= '0;
            cy           <= '0;
            colour       <= 1'b0;
`ifdef FB_CLEAR_ON_RESET_EN
            state        <= RUN;
            FILL_BUSY    <= 1'b1;
            x1           <= X_LAST;
            y1           <= Y_LAST;
`else
            state        <= IDLE;
            FILL_BUSY    <= 1'b0;
            x1           <= '0;
            y1           <= '0;
`endif
        end else begin
            // The CPU always owns the slot it asks for.
            if (CPU_REQ) begin
                FB_ADDR    <= {CPU_Y, CPU_X};
                FB_WE      <= CPU_WE & cpu_inr;
                FB_DATA_IN <= CPU_WDATA;
            end else if (fill_go) begin
                FB_ADDR    <= {cy, cx};
                FB_WE      <= 1'b1;
                FB_DATA_IN <= colour;
            end else begin
                FB_WE      <= 1'b0;
            end

            rd_p1        <= CPU_REQ & ~CPU_WE;
            ok1          <= cpu_inr;
            rd_p2        <= rd_p1;
            ok2          <= ok1;
            CPU_RD_VALID <= rd_p2;
            CPU_RD_DATA  <= rd_p2 & ok2 & FB_DATA_OUT;

            FILL_DONE <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (FILL_START && !FILL_BUSY) begin
                        x0        <= FILL_X0;
                        x1        <= fx1;
                        y0        <= FILL_Y0;
                        y1        <= fy1;
                        cx        <= FILL_X0;
                        cy        <= FILL_Y0;
                        colour    <= FILL_COLOUR;
                        FILL_BUSY <= 1'b1;
                        state     <= fill_ok ? RUN : DONE;
                    end else begin
                        FILL_BUSY <= 1'b0;
                    end
                end
                RUN: begin
                    if (fill_go) begin
                        if (cx == x1) begin
                            cx <= x0;
                            cy <= cy + 1'b1;
                            if (cy == y1) begin
                                state <= DONE;
                            end
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    FILL_DONE <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_port_a_ctrl.sv
// Bench for fb_port_a_ctrl: directed plan steps plus randomized CPU and fill traffic
// checked against a pixel-level shadow of the frame buffer.
module tb_fb_port_a_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CPU_REQ = 1'b0;
    logic        CPU_WE = 1'b0;
    logic [8:0]  CPU_X = '0;
    logic [7:0]  CPU_Y = '0;
    logic        CPU_WDATA = 1'b0;
    logic        CPU_RD_VALID;
    logic        CPU_RD_DATA;
    logic        FILL_START = 1'b0;
    logic [8:0]  FILL_X0 = '0;
    logic [8:0]  FILL_X1 = '0;
    logic [7:0]  FILL_Y0 = '0;
    logic [7:0]  FILL_Y1 = '0;
    logic        FILL_COLOUR = 1'b0;
    logic        FILL_BUSY;
    logic        FILL_DONE;
    logic [16:0] FB_ADDR;
    logic        FB_WE;
    logic        FB_DATA_IN;
    logic        FB_DATA_OUT = 1'b0;

    fb_port_a_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE),
        .CPU_X(CPU_X), .CPU_Y(CPU_Y),
        .CPU_WDATA(CPU_WDATA),
        .CPU_RD_VALID(CPU_RD_VALID),
        .CPU_RD_DATA(CPU_RD_DATA),
        .FILL_START(FILL_START),
        .FILL_X0(FILL_X0), .FILL_X1(FILL_X1),
        .FILL_Y0(FILL_Y0), .FILL_Y1(FILL_Y1),
        .FILL_COLOUR(FILL_COLOUR),
        .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE),
        .FB_ADDR(FB_ADDR), .FB_WE(FB_WE),
        .FB_DATA_IN(FB_DATA_IN), .FB_DATA_OUT(FB_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port frame buffer, read-first.
    bit fb_mem [0:131071];
    always @(posedge CLK) begin
        if (FB_WE === 1'b1) fb_mem[FB_ADDR] <= FB_DATA_IN;
        FB_DATA_OUT <= fb_mem[FB_ADDR];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef logic [17:0] wr_t;
    wr_t wq[$];
    int  done_cnt = 0;
    always @(negedge CLK) begin
        if (FB_WE === 1'b1) wq.push_back({FB_ADDR, FB_DATA_IN});
        if (FILL_DONE === 1'b1) done_cnt++;
    end

    // Expected pixel contents, by screen coordinate.
    bit shadow [0:131071];

    typedef struct { int due; bit val; } rd_t;
    rd_t rq[$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int pix(input int x, input int y);
        return y * 512 + x;
    endfunction

    function automatic bit on_screen(input int x, input int y);
        return (x < 320) && (y < 240);
    endfunction

    task automatic cpu_cycle(input bit req, input bit we, input int x,
                             input int y, input bit d);
        bit exp_v;
        CPU_REQ   = req;
        CPU_WE    = we;
        CPU_X     = 9'(x);
        CPU_Y     = 8'(y);
        CPU_WDATA = d;
        step();
        CPU_REQ = 1'b0;
        if (req) begin
            chk("cpu_addr", FB_ADDR, pix(x, y));
            chk("cpu_we", FB_WE, we && on_screen(x, y));
            if (we && on_screen(x, y)) shadow[pix(x, y)] = d;
            if (!we) rq.push_back('{cyc + 2, on_screen(x, y) ? shadow[pix(x, y)] : 1'b0});
        end else begin
            chk("idle_we", FB_WE, 0);
        end
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        chk("rd_valid", CPU_RD_VALID, exp_v);
        if (exp_v) begin
            chk("rd_data", CPU_RD_DATA, rq[0].val);
            void'(rq.pop_front());
        end
    endtask

    task automatic do_fill(input int x0, input int x1, input int y0,
                           input int y1, input bit col, input int k,
                           input int kx, input int ky, input int r);
        wr_t exp[$];
        int  n, s, mm, inj, ex1, ey1;
        bit  got;
        ex1 = (x1 > 319) ? 319 : x1;
        ey1 = (y1 > 239) ? 239 : y1;
        for (int y = y0; y <= ey1; y++)
            for (int x = x0; x <= ex1; x++)
                exp.push_back({17'(pix(x, y)), col});
        n   = exp.size();
        inj = (k >= 1 && k <= n) ? 1 : 0;
        if (inj == 1 && on_screen(kx, ky))
            exp.insert(k - 1, {17'(pix(kx, ky)), 1'b1});
        wq.delete();
        FILL_X0     = 9'(x0);
        FILL_X1     = 9'(x1);
        FILL_Y0     = 8'(y0);
        FILL_Y1     = 8'(y1);
        FILL_COLOUR = col;
        FILL_START  = 1'b1;
        step();
        s = cyc;
        FILL_START = 1'b0;
        chk("busy_rise", FILL_BUSY, 1);
        got = 1'b0;
        for (int fc = 1; fc <= n + 10; fc++) begin
            CPU_REQ   = (inj == 1 && fc == k);
            CPU_WE    = 1'b1;
            CPU_X     = 9'(kx);
            CPU_Y     = 8'(ky);
            CPU_WDATA = 1'b1;
            if (fc == r) begin
                FILL_START = 1'b1;
                FILL_X0 = 9'd0;
                FILL_X1 = 9'd1;
                FILL_Y0 = 8'd0;
                FILL_Y1 = 8'd1;
            end
            step();
            CPU_REQ    = 1'b0;
            FILL_START = 1'b0;
            if (FILL_DONE === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1);
        chk("done_lat", cyc - s, n + 1 + inj);
        step();
        chk("busy_fall", FILL_BUSY, 0);
        chk("done_pulse", FILL_DONE, 0);
        chk("wr_cnt", wq.size(), exp.size());
        mm = -1;
        for (int i = 0; i < wq.size() && i < exp.size(); i++)
            if (mm < 0 && wq[i] !== exp[i]) mm = i;
        chk("wr_seq", mm, -1);
        foreach (exp[i]) shadow[exp[i][17:1]] = exp[i][0];
    endtask

    initial begin
        int x0, y0, x1, y1, n, rsd0;
        repeat (3) step();
        chk("rst_we", FB_WE, 0);
        chk("rst_addr", FB_ADDR, 0);
        chk("rst_din", FB_DATA_IN, 0);
        chk("rst_rdv", CPU_RD_VALID, 0);
        chk("rst_rdd", CPU_RD_DATA, 0);
        chk("rst_busy", FILL_BUSY, 0);
        chk("rst_done", FILL_DONE, 0);
        RESET = 1'b0;
        step();
        chk("idle_busy", FILL_BUSY, 0);

        do_fill(10, 12, 5, 6, 1'b1, 0, 0, 0, 0);
        do_fill(10, 12, 5, 6, 1'b1, 3, 100, 100, 0);

        cpu_cycle(1, 1, 319, 239, 1);
        cpu_cycle(1, 0, 319, 239, 0);
        cpu_cycle(0, 0, 0, 0, 0);
        cpu_cycle(0, 0, 0, 0, 0);
        cpu_cycle(1, 1, 320, 0, 1);
        cpu_cycle(1, 0, 320, 0, 0);
        cpu_cycle(0, 0, 0, 0, 0);
        cpu_cycle(0, 0, 0, 0, 0);

        do_fill(300, 400, 230, 250, 1'b1, 0, 0, 0, 0);
        do_fill(50, 40, 0, 0, 1'b1, 0, 0, 0, 0);
        do_fill(20, 23, 30, 31, 1'b0, 0, 0, 0, 2);

        for (int i = 0; i < 300; i++) begin
            cpu_cycle(($urandom % 10) < 7, $urandom % 2,
                      $urandom_range(0, 330), $urandom_range(0, 250),
                      $urandom % 2);
            if (i % 4 == 0) cpu_cycle(1, 0, 319, 239, 0);
        end
        repeat (3) cpu_cycle(0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            x0 = $urandom_range(0, 330);
            y0 = $urandom_range(0, 250);
            x1 = x0 + $urandom_range(0, 6);
            y1 = y0 + $urandom_range(0, 3);
            if ($urandom % 4 == 0 && x0 > 0) x1 = x0 - 1;
            n = 0;
            if (x0 < 320 && y0 < 240) begin
                n = (((x1 > 319) ? 319 : x1) - x0 + 1);
                n = (n < 0) ? 0 : n * (((y1 > 239) ? 239 : y1) - y0 + 1);
            end
            do_fill(x0, x1, y0, y1, $urandom % 2, $urandom_range(0, n),
                    $urandom_range(0, 330), $urandom_range(0, 250), 0);
        end

        for (int i = 0; i < 120; i++)
            cpu_cycle(1, 0, $urandom_range(0, 330), $urandom_range(0, 250), 0);
        repeat (3) cpu_cycle(0, 0, 0, 0, 0);

        FILL_X0 = 9'd0;
        FILL_X1 = 9'd9;
        FILL_Y0 = 8'd0;
        FILL_Y1 = 8'd9;
        FILL_START = 1'b1;
        step();
        FILL_START = 1'b0;
        repeat (3) step();
        chk("mid_we", FB_WE, 1);
        RESET = 1'b1;
        step();
        chk("rstfill_we", FB_WE, 0);
        chk("rstfill_busy", FILL_BUSY, 0);
        chk("rstfill_done", FILL_DONE, 0);
        RESET = 1'b0;
        rsd0 = done_cnt;
        wq.delete();
        repeat (120) step();
        chk("rstfill_nodone", done_cnt - rsd0, 0);
        chk("rstfill_nowr", wq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fb_port_a_ctrl.md
Name: fb_port_a_ctrl

Overview:
- Owns write/read port A of the 320x240 1-bit frame buffer.
- Shares that port between two requesters:
  - the microprocessor's single-pixel read/write bus;
  - an internal rectangle-fill engine that writes one pixel per cycle.
- The microprocessor has absolute priority; the fill engine stalls while the bus is active.
- Drives the frame buffer with the {Y[7:0], X[8:0]} address format; the VGA read port is unaffected.

Parameters:
- HOR_RES, 320, horizontal resolution in pixels.
- VERT_RES, 240, vertical resolution in lines.
- X_W, 9, X coordinate width.
- Y_W, 8, Y coordinate width.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- CPU_REQ  input  1  single-cycle pixel access request.
- CPU_WE  input  1  1 = write, 0 = read; qualified by CPU_REQ.
- CPU_X  input  X_W  pixel X.
- CPU_Y  input  Y_W  pixel Y.
- CPU_WDATA  input  1  pixel write data.
- CPU_RD_VALID  output  1  read data valid pulse.
- CPU_RD_DATA  output  1  read pixel value.
- FILL_START  input  1  start pulse; operands sampled on the same cycle.
- FILL_X0, FILL_X1  input  X_W  inclusive X bounds.
- FILL_Y0, FILL_Y1  input  Y_W  inclusive Y bounds.
- FILL_COLOUR  input  1  fill pixel value.
- FILL_BUSY  output  1  engine active.
- FILL_DONE  output  1  one-cycle completion pulse.
- FB_ADDR  output  17  to frame buffer A_ADDR as {Y, X}.
- FB_WE  output  1  to A_WE.
- FB_DATA_IN  output  1  to A_DATA_IN.
- FB_DATA_OUT  input  1  from A_DATA_OUT.

Behaviour:
- Reset values: all outputs registered 0; FSM in IDLE; fill counters 0. Reset mid-fill aborts immediately with no FILL_DONE.
- FB_ADDR, FB_WE and FB_DATA_IN are registered: a request sampled at edge N appears on the frame buffer port after edge N.
- CPU path:
  - CPU_REQ=1 is always serviced in the cycle it is sampled; no backpressure.
  - CPU write with X >= HOR_RES or Y >= VERT_RES: FB_WE held 0, but the access still consumes the slot.
  - CPU read: CPU_RD_VALID pulses high exactly 2 cycles after the request edge. CPU_RD_DATA equals FB_DATA_OUT during that cycle, or 0 if the read was out of range.
  - Back-to-back reads on consecutive cycles are pipelined, one result per cycle.
- Fill FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - On FILL_START, latch operands.
  - Clamp X1 to min(X1, HOR_RES-1) and Y1 to min(Y1, VERT_RES-1).
  - If X0 > clamped X1, or Y0 > clamped Y1, or X0 >= HOR_RES, or Y0 >= VERT_RES, go to DONE with zero writes.
  - Otherwise set cx=X0, cy=Y0 and go to RUN.
  - FILL_BUSY=1 from the cycle after FILL_START until the cycle FILL_DONE pulses, inclusive.
- RUN:
  - Each cycle with CPU_REQ=0, issue a write of {cy, cx} with FILL_COLOUR and advance.
  - Advance order: raster, X inner. If cx = X1, set cx=X0 and cy+1; if additionally cy = Y1, go to DONE.
  - A cycle with CPU_REQ=1 issues the CPU access instead; cx/cy hold.
- DONE: FILL_DONE=1 for one cycle, then return to IDLE.
- FILL_START while FILL_BUSY=1 is ignored.
- Write count for an in-range rectangle: (X1-X0+1)*(Y1-Y0+1). Completion latency with no CPU traffic is that count + 1 cycles from the start edge to the FILL_DONE edge.
- Counter arithmetic is X_W/Y_W bits wide; clamping guarantees cx/cy never wrap.

Optional Feature:
- Macro: FB_CLEAR_ON_RESET_EN.
- Defined:
  - On reset release, the FSM enters RUN with a full-screen rectangle (0,0)-(HOR_RES-1,VERT_RES-1) and colour 0.
  - FILL_BUSY=1 during this clear; FILL_DONE pulses at its end; FILL_START is ignored until then.
  - CPU priority still applies.
- Undefined: after reset the FSM sits in IDLE and frame buffer contents are untouched.

Test Plan:
- Fill (10,5)-(12,6), colour 1, no CPU traffic -> exactly 6 FB_WE pulses at addresses {5,10},{5,11},{5,12},{6,10},{6,11},{6,12}; FILL_DONE 7 cycles after FILL_START.
- Same fill, with CPU_REQ write (100,100)=1 asserted on the 3rd fill cycle -> CPU write appears that cycle; fill resumes at {5,12}; 7 total FB_WE pulses; FILL_DONE delayed by 1 cycle.
- CPU write (319,239)=1 then read (319,239) -> CPU_RD_VALID 2 cycles after the read request, with CPU_RD_DATA=1. Write (320,0) -> FB_WE stays 0; a read of (320,0) returns 0.
- Fill (300,230)-(400,250) -> clamped to (300,230)-(319,239); 200 writes. Fill (50,0)-(40,0) -> zero writes; FILL_DONE 1 cycle after FILL_BUSY rises.
- FILL_START during a fill -> ignored. RESET asserted mid-fill -> FB_WE 0 on the next cycle, no FILL_DONE, FILL_BUSY 0.
- With FB_CLEAR_ON_RESET_EN defined, release reset -> 76800 writes of 0 in raster order, then a FILL_DONE pulse.
